// File: rtl/alu_pkg.sv
// Shared types for the ALU command sequencer: opcode and sequencer state encodings.
package alu_pkg;

  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    DIV   = 3'd2,
    MUL   = 3'd3,
    MOD   = 3'd4,
    SLT   = 3'd5,
    SEQ   = 3'd6,
    LOADI = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPND = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } alu_seq_state_e;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two combinational read ports, a debug read port and one
// synchronous write port. Entry 0 always reads as zero and ignores writes.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_a  = (raddr_a  == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b  = (raddr_b  == '0) ? '0 : mem_q[raddr_b];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem_q[dbg_addr];

endmodule

// File: rtl/alu_seq.sv
// Command-driven sequencer around a purely combinational ALU: fetches operands,
// drives the ALU, applies the zero-divisor policy and writes the result back.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int NREGS  = 8,
  parameter int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_rd,
  input  logic [REG_AW-1:0] cmd_rs1,
  input  logic [REG_AW-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_res,
  output logic              rsp_valid,
  output logic [REG_AW-1:0] rsp_rd,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  alu_seq_state_e    state_q, state_d;
  alu_op_e           op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  alu_op_e           alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [REG_AW-1:0] rsp_rd_q, rsp_rd_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rs1_data, rs2_data;

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (state_q == WB),
    .waddr    (rsp_rd_q),
    .wdata    (rsp_data_q),
    .raddr_a  (rs1_q),
    .rdata_a  (rs1_data),
    .raddr_b  (rs2_q),
    .rdata_b  (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    imm_d       = imm_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = alu_op_e'(cmd_op);
          rd_d    = cmd_rd;
          rs1_d   = cmd_rs1;
          rs2_d   = cmd_rs2;
          imm_d   = cmd_imm;
          state_d = OPND;
        end
      end
      OPND: begin
        if (op_q == LOADI) begin
          alu_a_d  = imm_q;
          alu_b_d  = '0;
          alu_op_d = ADD;
        end else begin
          alu_a_d  = rs1_data;
          alu_b_d  = rs2_data;
          alu_op_d = op_q;
        end
        state_d = EXEC;
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_rd_d    = rd_q;
        // A zero divisor overrides whatever the ALU produces.
        if ((alu_op_q == DIV) && (alu_b_q == '0)) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
        end else if ((alu_op_q == MOD) && (alu_b_q == '0)) begin
          rsp_data_d = alu_a_q;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_data_d = alu_res;
          rsp_err_d  = 1'b0;
        end
        state_d = WB;
      end
      WB: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= ADD;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ADD;
      rsp_valid_q <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_q       <= imm_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Gated by rst_n so the source never sees ready while the block is held in reset.
  assign cmd_ready = (state_q == IDLE) && rst_n;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rd    = rsp_rd_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: stub ALU, directed vector table, random commands against a
// register-array reference model, back-to-back handshake and reset-mid-op sequences.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic [DW-1:0] cmd_imm;
  logic [DW-1:0] alu_a, alu_b;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_res;
  logic          rsp_valid;
  logic [AW-1:0] rsp_rd;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  alu_seq #(.DATA_W(DW), .NREGS(NR), .REG_AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs1   (cmd_rs1),
    .cmd_rs2   (cmd_rs2),
    .cmd_imm   (cmd_imm),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_rd    (rsp_rd),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub ALU; divide/mod by zero return junk the sequencer must override.
  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'd0: alu_res = alu_a + alu_b;
      3'd1: alu_res = alu_a - alu_b;
      3'd2: alu_res = (alu_b == 0) ? 32'hDEAD_BEEF : alu_a / alu_b;
      3'd3: alu_res = alu_a * alu_b;
      3'd4: alu_res = (alu_b == 0) ? 32'h0BAD_F00D : alu_a % alu_b;
      3'd5: alu_res = {31'b0, alu_a < alu_b};
      3'd6: alu_res = {31'b0, alu_a == alu_b};
      default: alu_res = 32'h5555_AAAA;
    endcase
  end

  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;
  logic [DW-1:0] ref_regs [NR];

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    if (rst_n && rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm;
    logic [DW-1:0] exp_data;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int op, int rd, int rs1, int rs2, logic [DW-1:0] imm,
                              logic [DW-1:0] d, logic e);
    vec_t v;
    v.op = 3'(op); v.rd = 3'(rd); v.rs1 = 3'(rs1); v.rs2 = 3'(rs2);
    v.imm = imm; v.exp_data = d; v.exp_err = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference semantics straight from the command definitions.
  function automatic void model(input logic [2:0] op, input logic [AW-1:0] rs1, rs2,
                                input logic [DW-1:0] imm,
                                output logic [DW-1:0] d, output logic e);
    logic [DW-1:0] a, b;
    a = ref_regs[rs1];
    b = ref_regs[rs2];
    e = 1'b0;
    case (op)
      3'd0: d = a + b;
      3'd1: d = a - b;
      3'd2: if (b == 0) begin d = 32'hFFFF_FFFF; e = 1'b1; end else d = a / b;
      3'd3: d = a * b;
      3'd4: if (b == 0) begin d = a; e = 1'b1; end else d = a % b;
      3'd5: d = (a < b) ? 32'd1 : 32'd0;
      3'd6: d = (a == b) ? 32'd1 : 32'd0;
      default: d = imm;
    endcase
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_cmd(input logic [2:0] op, input logic [AW-1:0] rd, rs1, rs2,
                         input logic [DW-1:0] imm, exp_data, input logic exp_err,
                         input bit keep, input string name);
    logic [7:0] pat;
    int guard;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    dbg_addr = rd;
    guard = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check({name, " accept timeout"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    pat = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pat[7-k] = rsp_valid;
      pat[3-k] = cmd_ready;
      if (k == 0 && !keep) cmd_valid = 1'b0;
      if (k == 2) begin
        check({name, " data"}, 64'(rsp_data), 64'(exp_data));
        check({name, " err"},  64'(rsp_err),  64'(exp_err));
        check({name, " rd"},   64'(rsp_rd),   64'(rd));
      end
      if (k == 3) begin
        if (rd != 0) ref_regs[rd] = exp_data;
        check({name, " dbg"}, 64'(dbg_data), 64'(ref_regs[rd]));
      end
    end
    check({name, " timing"}, 64'(pat), 64'h21);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] d;
    logic e;
    logic [2:0] op;
    logic [AW-1:0] rd, rs1, rs2;
    logic [DW-1:0] imm;
    int a0, r0c;

    for (int i = 0; i < NR; i++) ref_regs[i] = '0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0;
    cmd_rs2 = '0; cmd_imm = '0; dbg_addr = '0;

    repeat (3) @(negedge clk);
    check("reset cmd_ready", 64'(cmd_ready), 64'd0);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset outputs", {alu_a, alu_b}, 64'd0);
    check("reset rsp", {29'd0, alu_op, rsp_data}, {29'd0, 3'd0, 32'd0});
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready after release", 64'(cmd_ready), 64'd1);

    vecs.push_back(mk(7, 1, 0, 0, 32'd7, 32'd7, 1'b0));
    vecs.push_back(mk(7, 2, 0, 0, 32'd3, 32'd3, 1'b0));
    vecs.push_back(mk(0, 3, 1, 2, 32'd0, 32'd10, 1'b0));
    vecs.push_back(mk(1, 3, 1, 2, 32'd0, 32'd4, 1'b0));
    vecs.push_back(mk(2, 3, 1, 2, 32'd0, 32'd2, 1'b0));
    vecs.push_back(mk(3, 3, 1, 2, 32'd0, 32'd21, 1'b0));
    vecs.push_back(mk(4, 3, 1, 2, 32'd0, 32'd1, 1'b0));
    vecs.push_back(mk(5, 3, 1, 2, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mk(6, 3, 1, 2, 32'd0, 32'd0, 1'b0));
    vecs.push_back(mk(5, 3, 2, 1, 32'd0, 32'd1, 1'b0));
    vecs.push_back(mk(6, 3, 1, 1, 32'd0, 32'd1, 1'b0));
    vecs.push_back(mk(1, 3, 2, 1, 32'd0, 32'hFFFF_FFFC, 1'b0));
    vecs.push_back(mk(2, 4, 1, 0, 32'd0, 32'hFFFF_FFFF, 1'b1));
    vecs.push_back(mk(4, 4, 1, 0, 32'd0, 32'd7, 1'b1));
    vecs.push_back(mk(0, 4, 1, 2, 32'd0, 32'd10, 1'b0));
    vecs.push_back(mk(7, 0, 0, 0, 32'd5, 32'd5, 1'b0));
    vecs.push_back(mk(7, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0));
    vecs.push_back(mk(0, 1, 1, 1, 32'd0, 32'hFFFF_FFFE, 1'b0));

    foreach (vecs[i]) begin
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
              vecs[i].exp_data, vecs[i].exp_err, 1'b0, $sformatf("vec%0d", i));
    end
    dbg_addr = '0;
    #1 check("r0 stays zero", 64'(dbg_data), 64'd0);

    // Back-to-back with cmd_valid held high throughout.
    a0 = acc_cnt; r0c = rsp_cnt;
    for (int i = 0; i < 4; i++) begin
      rd = 3'(i + 4);
      imm = 32'h100 + 32'(i);
      model(3'd7, 3'd0, 3'd0, imm, d, e);
      run_cmd(3'd7, rd, 3'd0, 3'd0, imm, d, e, (i != 3), $sformatf("b2b%0d", i));
    end
    repeat (3) @(negedge clk);
    check("b2b accept count", 64'(acc_cnt - a0), 64'd4);
    check("b2b rsp count", 64'(rsp_cnt - r0c), 64'd4);

    // Random commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      rd  = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: imm = 32'd0;
        1: imm = 32'($urandom_range(0, 15));
        default: imm = $urandom;
      endcase
      model(op, rs1, rs2, imm, d, e);
      run_cmd(op, rd, rs1, rs2, imm, d, e, 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset asserted while the command is in EXEC.
    model(3'd7, 3'd0, 3'd0, 32'h55, d, e);
    run_cmd(3'd7, 3'd5, 3'd0, 3'd0, 32'h55, d, e, 1'b0, "pre-reset loadi");
    r0c = rsp_cnt;
    cmd_op = 3'd0; cmd_rd = 3'd6; cmd_rs1 = 3'd5; cmd_rs2 = 3'd5; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midop cmd_ready", 64'(cmd_ready), 64'd0);
    check("midop rsp_valid", 64'(rsp_valid), 64'd0);
    check("midop outputs", {alu_a, rsp_data}, 64'd0);
    for (int i = 0; i < NR; i++) begin
      dbg_addr = 3'(i);
      #1 check($sformatf("midop r%0d", i), 64'(dbg_data), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midop no rsp", 64'(rsp_cnt - r0c), 64'd0);
    for (int i = 0; i < NR; i++) ref_regs[i] = '0;
    model(3'd7, 3'd0, 3'd0, 32'd9, d, e);
    run_cmd(3'd7, 3'd6, 3'd0, 3'd0, 32'd9, d, e, 1'b0, "post-reset loadi");
    model(3'd0, 3'd6, 3'd6, 32'd0, d, e);
    run_cmd(3'd0, 3'd2, 3'd6, 3'd6, 32'd0, d, e, 1'b0, "post-reset add");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
